// File: rtl/baby_run_controller_pkg.sv
// Shared constants for the Manchester Baby run controller.
// Holds default widths, the default run-cycle limit and the FSM state encodings.
package baby_run_controller_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF    = 5;
    localparam int unsigned RUN_CNT_W_DEF = 24;
    localparam logic [23:0] MAX_RUN_DEF   = 24'hFFFFFF;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DUMP = 2'd3;

endpackage

// File: rtl/baby_run_timer.sv
// Run-cycle counter for one Baby job.
// Ports: clock/reset_i (async active-high); clear_i zeroes the count, enable_i
// advances it by one per cycle; term_c is high while the count sits at MAX_RUN-1.
module baby_run_timer
    import baby_run_controller_pkg::*;
#(
    parameter int unsigned            RUN_CNT_W = RUN_CNT_W_DEF,
    parameter logic [RUN_CNT_W-1:0]   MAX_RUN   = RUN_CNT_W'(MAX_RUN_DEF)
) (
    input  logic clock,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic term_c
);

    logic [RUN_CNT_W-1:0] run_cnt_q;
    logic [RUN_CNT_W-1:0] run_cnt_d;

    // Clear has priority so a fresh job always starts from zero.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (clear_i) begin
            run_cnt_d = '0;
        end else if (enable_i) begin
            run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    // Terminal on the last permitted RUN cycle, so RUN lasts exactly MAX_RUN cycles.
    assign term_c = (run_cnt_q == (MAX_RUN - RUN_CNT_W'(1)));

endmodule

// File: rtl/baby_run_controller.sv
// Sequences one Manchester Baby job: load 32 words from the host into the store,
// run the CPU until stop lamp or cycle limit, then stream the store back out.
// Ports: clock/reset_i (async active-high); host_* load stream, start and abort;
// dump_* output stream; cpu_* connect to the manchester_baby core; mem_* drive the
// single 32-word store port; busy_o/halted_o/timeout_o report job status.
module baby_run_controller
    import baby_run_controller_pkg::*;
#(
    parameter int unsigned          DATA_W    = DATA_W_DEF,
    parameter int unsigned          ADDR_W    = ADDR_W_DEF,
    parameter int unsigned          RUN_CNT_W = RUN_CNT_W_DEF,
    parameter logic [RUN_CNT_W-1:0] MAX_RUN   = RUN_CNT_W'(MAX_RUN_DEF)
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic              host_start_i,
    input  logic              host_abort_i,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic              cpu_reset_o,
    input  logic [ADDR_W-1:0] cpu_ram_addr_i,
    input  logic [DATA_W-1:0] cpu_ram_wdata_i,
    input  logic              cpu_ram_rw_en_i,
    output logic [DATA_W-1:0] cpu_ram_rdata_o,
    input  logic              cpu_stop_lamp_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              halted_o,
    output logic              timeout_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic               host_ready_q, host_ready_d;
    logic               dump_valid_q, dump_valid_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               busy_q, busy_d;

    logic               timer_clear;
    logic               timer_en;
    logic               timer_term;
    logic               last_word;

    assign last_word = &word_cnt_q;

    baby_run_timer #(
        .RUN_CNT_W (RUN_CNT_W),
        .MAX_RUN   (MAX_RUN)
    ) u_timer (
        .clock    (clock),
        .reset_i  (reset_i),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .term_c   (timer_term)
    );

    // Next-state, word counter and sticky status.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                word_cnt_d  = '0;
                // Status survives in IDLE so the host can read it; a new job clears it.
                if (host_start_i && !host_abort_i) begin
                    state_d   = ST_LOAD;
                    halted_d  = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (host_abort_i) begin
                    state_d    = ST_IDLE;
                    word_cnt_d = '0;
                end else if (host_valid_i) begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    if (last_word) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                timer_en = 1'b1;
                if (host_abort_i) begin
                    state_d    = ST_IDLE;
                    word_cnt_d = '0;
                end else if (cpu_stop_lamp_i) begin
                    // Stop lamp outranks the limit when both land on the same cycle.
                    state_d  = ST_DUMP;
                    halted_d = 1'b1;
                end else if (timer_term) begin
                    state_d   = ST_DUMP;
                    timeout_d = 1'b1;
                end
            end
            ST_DUMP: begin
                if (host_abort_i) begin
                    state_d    = ST_IDLE;
                    word_cnt_d = '0;
                end else if (dump_ready_i) begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    if (last_word) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                word_cnt_d = '0;
            end
        endcase

        host_ready_d = (state_d == ST_LOAD);
        dump_valid_d = (state_d == ST_DUMP);
        cpu_reset_d  = (state_d != ST_RUN);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            host_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            host_ready_q <= host_ready_d;
            dump_valid_q <= dump_valid_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
        end
    end

    // Store-port mux: CPU only owns the port in RUN, so load/dump can never be disturbed by it.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                mem_addr_o  = word_cnt_q;
                mem_wdata_o = host_data_i;
                mem_we_o    = host_valid_i;
            end
            ST_RUN: begin
                mem_addr_o  = cpu_ram_addr_i;
                mem_wdata_o = cpu_ram_wdata_i;
                mem_we_o    = cpu_ram_rw_en_i;
            end
            ST_DUMP: begin
                mem_addr_o = word_cnt_q;
            end
            default: begin
                mem_addr_o = '0;
            end
        endcase
    end

    // Dump data stays stable under backpressure: address held, store not written.
    assign dump_addr_o     = word_cnt_q;
    assign dump_data_o     = (state_q == ST_DUMP) ? mem_rdata_i : '0;
    assign cpu_ram_rdata_o = mem_rdata_i;

    assign host_ready_o = host_ready_q;
    assign dump_valid_o = dump_valid_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign busy_o       = busy_q;
    assign halted_o     = halted_q;
    assign timeout_o    = timeout_q;

endmodule
